fu_pipe: RTL and testbench



---
 rtl/fu_pkg.sv | 27 ++
 rtl/fu_mul_pipe.sv | 40 ++++
 rtl/fu_pipe.sv | 108 ++++++++++
 tb/tb_fu_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// fu_pkg: opcodes, flag bit positions and op-class helper shared by the functional unit
package fu_pkg;
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_NOTA = 5'd5;
    localparam logic [4:0] OP_NEGA = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_SHR  = 5'd8;
    localparam logic [4:0] OP_ASHR = 5'd9;
    localparam logic [4:0] OP_INC  = 5'd10;
    localparam logic [4:0] OP_DEC  = 5'd11;
    localparam logic [4:0] OP_LT   = 5'd12;
    localparam logic [4:0] OP_EQ   = 5'd13;
    localparam logic [4:0] OP_LTU  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_MADD = 5'd16;
    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;
    function automatic logic is_long(input logic [4:0] op);
        return op == OP_MUL || op == OP_MADD;
    endfunction
endpackage

// File: rtl/fu_mul_pipe.sv
// fu_mul_pipe: multiply-add front stages; the last stage here feeds the unit's output register
module fu_mul_pipe
    import fu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic             madd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_z,
    output logic             busy
);
    localparam int N = MUL_LAT - 1;
    logic [N-1:0]            v;
    logic [N-1:0][WIDTH-1:0] d;
    // stage 0 captures the product (C forced to 0 for MUL); later stages shift it along under the global enable
    always_ff @(posedge clock) begin
        if (reset) begin
            v <= '0;
            d <= '0;
        end else if (en) begin
            v[0] <= in_valid;
            d[0] <= a * b + (madd ? c : '0);
            for (int i = 1; i < N; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end
    assign out_valid = v[N-1];
    assign out_z     = d[N-1];
    assign busy      = |v;
endmodule

// File: rtl/fu_pipe.sv
// fu_pipe: handshaked functional unit; short ops land in the output register, multiplies go through fu_mul_pipe
module fu_pipe
    import fu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [4:0]       INST,
    input  logic             CI,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Z,
    output logic [3:0]       FLAGS,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);
    localparam int SW = $clog2(WIDTH);
    logic             advance, accept, long_op, short_acc, busy, mul_valid;
    logic [WIDTH-1:0] mul_z, sz, ax, ay;
    logic [WIDTH:0]   sum, shl, shr, ashr;
    logic [SW-1:0]    amt;
    logic             acin, cy, ov;
    logic [3:0]       sf, mf;

    assign long_op   = is_long(INST);
    assign advance   = !OUT_VALID || OUT_READY;
    assign IN_READY  = advance && !RESET && !(IN_VALID && !long_op && busy);
    assign accept    = IN_VALID && IN_READY;
    assign short_acc = accept && !long_op;
    assign amt       = B[SW-1:0];

    fu_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul (
        .clock    (CLOCK),
        .reset    (RESET),
        .en       (advance),
        .in_valid (accept && long_op),
        .madd     (INST == OP_MADD),
        .a        (A),
        .b        (B),
        .c        (C),
        .out_valid(mul_valid),
        .out_z    (mul_z),
        .busy     (busy)
    );

    // short-op datapath: one shared adder for the arithmetic ops, widened shifters expose the last bit shifted out
    always_comb begin
        ax   = INST == OP_NEGA ? '0 : A;
        ay   = INST == OP_ADD ? B : INST == OP_SUB ? ~B : INST == OP_NEGA ? ~A : INST == OP_DEC ? '1 : '0;
        acin = INST == OP_ADD ? CI : (INST == OP_SUB || INST == OP_NEGA || INST == OP_INC);
        sum  = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, acin};
        shl  = {1'b0, A} << amt;
        shr  = {A, 1'b0} >> amt;
        ashr = $signed({A, 1'b0}) >>> amt;
        sz   = '0;
        cy   = 1'b0;
        ov   = 1'b0;
        case (INST)
            OP_ADD, OP_SUB, OP_NEGA, OP_INC, OP_DEC: begin
                sz = sum[WIDTH-1:0];
                cy = sum[WIDTH];
                ov = ax[WIDTH-1] == ay[WIDTH-1] && sum[WIDTH-1] != ax[WIDTH-1];
            end
            OP_AND:  sz = A & B;
            OP_OR:   sz = A | B;
            OP_XOR:  sz = A ^ B;
            OP_NOTA: sz = ~A;
            OP_SHL:  {cy, sz} = shl;
            OP_SHR:  {sz, cy} = shr;
            OP_ASHR: {sz, cy} = ashr;
            OP_LT:   sz = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_EQ:   sz = {{(WIDTH-1){1'b0}}, A == B};
            OP_LTU:  sz = {{(WIDTH-1){1'b0}}, A < B};
            default: sz = '0;
        endcase
        sf             = '0;
        sf[FLAG_ZERO]  = sz == '0;
        sf[FLAG_NEG]   = sz[WIDTH-1];
        sf[FLAG_CARRY] = cy;
        sf[FLAG_OVF]   = ov;
        mf             = '0;
        mf[FLAG_ZERO]  = mul_z == '0;
        mf[FLAG_NEG]   = mul_z[WIDTH-1];
    end

    // output stage: a finishing multiply and an accepted short op never coincide thanks to the interlock
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            OUT_VALID <= 1'b0;
            Z         <= '0;
            FLAGS     <= '0;
        end else if (advance) begin
            OUT_VALID <= mul_valid || short_acc;
            if (mul_valid) begin
                Z     <= mul_z;
                FLAGS <= mf;
            end else if (short_acc) begin
                Z     <= sz;
                FLAGS <= sf;
            end
        end
    end
endmodule

// File: tb/tb_fu_pipe.sv
// tb_fu_pipe: random and directed stimulus against an in-order queue model of the functional unit
module tb_fu_pipe;
    localparam int LAT = 2;
    localparam logic [4:0] T_ADD = 0, T_SUB = 1, T_AND = 2, T_OR = 3, T_XOR = 4, T_NOTA = 5,
                           T_NEGA = 6, T_SHL = 7, T_SHR = 8, T_ASHR = 9, T_INC = 10, T_DEC = 11,
                           T_LT = 12, T_EQ = 13, T_LTU = 14, T_MUL = 15, T_MADD = 16;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] A = '0, B = '0, C = '0;
    logic [4:0]  INST = '0;
    logic        CI = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b1;
    logic        IN_READY, OUT_VALID;
    logic [31:0] Z;
    logic [3:0]  FLAGS;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  f;
        int          rem;
        bit          lng;
    } item_t;
    item_t q[$];
    int n_checks = 0, n_fail = 0, dut_pops = 0;

    fu_pipe #(.WIDTH(32), .MUL_LAT(LAT)) dut (
        .CLOCK(clk), .RESET(RESET), .A(A), .B(B), .C(C), .INST(INST), .CI(CI),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Z(Z), .FLAGS(FLAGS),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit t_long(input logic [4:0] op);
        return op == T_MUL || op == T_MADD;
    endfunction

    function automatic logic [35:0] ref_fu(input logic [4:0] op, input logic [31:0] a, b, c, input logic ci);
        logic [31:0] z;
        logic        cy, ov;
        int          sh;
        longint      s;
        z = '0; cy = 1'b0; ov = 1'b0;
        sh = int'(b[4:0]);
        case (op)
            T_ADD: begin
                s  = longint'(a) + longint'(b) + longint'(ci);
                z  = s[31:0];
                cy = s >= 64'sd4294967296;
                s  = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
                ov = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            T_SUB: begin
                z  = a - b;
                cy = a >= b;
                s  = longint'($signed(a)) - longint'($signed(b));
                ov = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            T_AND:  z = a & b;
            T_OR:   z = a | b;
            T_XOR:  z = a ^ b;
            T_NOTA: z = ~a;
            T_NEGA: begin z = 32'd0 - a; cy = a == 0; ov = a == 32'h8000_0000; end
            T_SHL:  begin z = a << sh; cy = sh != 0 ? a[32-sh] : 1'b0; end
            T_SHR:  begin z = a >> sh; cy = sh != 0 ? a[sh-1] : 1'b0; end
            T_ASHR: begin z = $signed(a) >>> sh; cy = sh != 0 ? a[sh-1] : 1'b0; end
            T_INC:  begin z = a + 1; cy = a == 32'hFFFF_FFFF; ov = a == 32'h7FFF_FFFF; end
            T_DEC:  begin z = a - 1; cy = a != 0; ov = a == 32'h8000_0000; end
            T_LT:   z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            T_EQ:   z = (a == b) ? 32'd1 : 32'd0;
            T_LTU:  z = (a < b) ? 32'd1 : 32'd0;
            T_MUL:  z = a * b;
            T_MADD: z = a * b + c;
            default: z = '0;
        endcase
        return {z == 0, z[31], cy, ov, z};
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rnd_op();
        return ($urandom_range(0, 3) == 0) ? 5'(15 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
    endfunction

    // one clock cycle: drive, compare DUT against the model mid-cycle, then advance the model across the edge
    task automatic step(input bit rs, iv, input logic [4:0] op, input logic [31:0] a, b, c,
                        input bit ci, ordy, input int want_ir, output bit acc);
        bit          ov_e, adv, lif, ir_e;
        logic [35:0] r;
        @(negedge clk);
        RESET = rs; IN_VALID = iv; INST = op; A = a; B = b; C = c; CI = ci; OUT_READY = ordy;
        #1;
        ov_e = q.size() > 0 && q[0].rem == 0;
        adv  = !ov_e || ordy;
        lif  = 1'b0;
        foreach (q[i]) if (q[i].lng && q[i].rem > 0) lif = 1'b1;
        ir_e = adv && !rs && !(iv && !t_long(op) && lif);
        check("in_ready", IN_READY, ir_e);
        if (want_ir >= 0) check("in_ready_directed", IN_READY, want_ir);
        check("out_valid", OUT_VALID, ov_e);
        if (ov_e) begin
            check("z", Z, q[0].z);
            check("flags", FLAGS, q[0].f);
        end
        if (OUT_VALID === 1'b1 && ordy) dut_pops++;
        acc = iv && ir_e;
        @(posedge clk);
        if (rs) q.delete();
        else if (adv) begin
            if (ov_e) void'(q.pop_front());
            foreach (q[i]) if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
            if (acc) begin
                r = ref_fu(op, a, b, c, ci);
                q.push_back('{r[31:0], r[35:32], t_long(op) ? LAT - 1 : 0, t_long(op)});
            end
        end
    endtask

    initial begin
        bit          acc;
        int          k, cyc, p0;
        logic [4:0]  op;
        logic [31:0] ra, rb, rc;
        logic        rci;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, acc);
        #1;
        check("reset_valid", OUT_VALID, 0);
        check("reset_z", Z, 0);
        check("reset_flags", FLAGS, 0);

        step(0, 1, T_ADD, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 1, acc);
        #1;
        check("add_valid", OUT_VALID, 1);
        check("add_z", Z, 32'h0);
        check("add_flags", FLAGS, 4'b1010);
        step(0, 1, T_SUB, 32'h8000_0000, 32'h1, 0, 0, 1, 1, acc);
        #1;
        check("sub_z", Z, 32'h7FFF_FFFF);
        check("sub_flags", FLAGS, 4'b0011);
        step(0, 1, T_ASHR, 32'h8000_0000, 32'h24, 0, 0, 1, 1, acc);
        #1;
        check("ashr_z", Z, 32'hF800_0000);
        check("ashr_flags", FLAGS, 4'b0100);

        step(0, 1, T_MADD, 3, 5, 7, 0, 1, 1, acc);
        step(0, 1, T_ADD, 1, 1, 0, 0, 1, 0, acc);
        #1;
        check("madd_valid", OUT_VALID, 1);
        check("madd_z", Z, 32'h16);
        step(0, 1, T_ADD, 1, 1, 0, 0, 1, 1, acc);
        #1;
        check("after_madd_z", Z, 32'h2);

        step(0, 1, T_MADD, 9, 9, 9, 0, 1, 1, acc);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, acc);
        #1;
        check("midreset_valid", OUT_VALID, 0);
        check("midreset_z", Z, 0);
        check("midreset_flags", FLAGS, 0);
        step(0, 1, T_ADD, 5, 6, 0, 0, 1, 1, acc);
        #1;
        check("post_reset_z", Z, 32'd11);
        check("post_reset_flags", FLAGS, 4'b0000);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, -1, acc);

        p0 = dut_pops; k = 0; cyc = 0;
        op = rnd_op(); ra = rnd_val(); rb = rnd_val(); rc = rnd_val(); rci = 1'($urandom_range(0, 1));
        while (k < 6 && cyc < 60) begin
            step(0, 1, op, ra, rb, rc, rci, !(cyc >= 2 && cyc <= 4), -1, acc);
            if (acc) begin
                k++;
                op = rnd_op(); ra = rnd_val(); rb = rnd_val(); rc = rnd_val(); rci = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        check("stream_accepted", k, 6);
        repeat (6) step(0, 0, 0, 0, 0, 0, 0, 1, -1, acc);
        check("stream_emitted", dut_pops - p0, 6);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rnd_op(), rnd_val(), rnd_val(),
                 rnd_val(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, -1, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
